edge_frame_sequencer: RTL

//  Frame-level controller for the edge-detection pipeline, on the pixel clock.

---
 rtl/edge_frame_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/edge_frame_sequencer.sv
// Frame-level controller for the edge-detection pipeline: tracks frame/pixel position,
// gates the datapath, and restarts the timing generator after the datapath latency.
module edge_frame_sequencer #(
    parameter int unsigned H_ACT    = 640,
    parameter int unsigned V_ACT    = 480,
    parameter int unsigned PIPE_LAT = 1286,
    parameter int unsigned CNT_W    = 12
) (
    input  logic             I_CLK,
    input  logic             I_RST_N,
    input  logic             I_ENABLE,
    input  logic             I_VSYNC,
    input  logic             I_DE,
    input  logic             I_ERR_CLR,
    output logic             O_PIPE_EN,
    output logic             O_VRST,
    output logic [CNT_W-1:0] O_PIX_COL,
    output logic [CNT_W-1:0] O_PIX_ROW,
    output logic [2:0]       O_STATE,
    output logic             O_ERR,
    output logic [15:0]      O_FRAME_CNT
);

    localparam int unsigned FC_W = 16;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_ACT - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_ACT - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_FILL  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic              vs_dly_q, de_dly_q;
    logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic              done_q, done_d;
    logic              pipe_en_q, pipe_en_d;
    logic              vrst_q, vrst_d;
    logic [CNT_W-1:0]  pix_col_q, pix_col_d;
    logic [CNT_W-1:0]  pix_row_q, pix_row_d;
    logic              err_q, err_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic              err_set;
    logic              vs_rise;
    logic              last_pix;

    assign vs_rise  = I_VSYNC & ~vs_dly_q;
    assign last_pix = I_DE && (col_q == COL_LAST) && (row_q == ROW_LAST);

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        col_d       = col_q;
        row_d       = row_q;
        done_d      = done_q;
        pix_col_d   = pix_col_q;
        pix_row_d   = pix_row_q;
        frame_cnt_d = frame_cnt_q;
        vrst_d      = 1'b0;
        err_set     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_ENABLE) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!I_ENABLE) begin
                    state_d = ST_IDLE;
                end else if (vs_rise) begin
                    state_d   = ST_FILL;
                    lat_cnt_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                    done_d    = 1'b0;
                end
            end
            ST_FILL, ST_RUN: begin
                if (vs_rise) begin
                    // early frame: restart the fill window, suppress this cycle's restart pulse
                    err_set   = 1'b1;
                    state_d   = ST_FILL;
                    lat_cnt_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                    done_d    = 1'b0;
                end else begin
                    if (!done_q) begin
                        if (I_DE) begin
                            pix_col_d = col_q;
                            pix_row_d = row_q;
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                row_d = row_q + CNT_W'(1);
                            end else begin
                                col_d = col_q + CNT_W'(1);
                            end
                            if (last_pix) done_d = 1'b1;
                        end else if (de_dly_q && (col_q != '0)) begin
                            err_set = 1'b1;
                            col_d   = '0;
                            row_d   = row_q + CNT_W'(1);
                        end
                    end
                    if (state_q == ST_FILL) begin
                        lat_cnt_d = lat_cnt_q + CNT_W'(1);
                        if (lat_cnt_q == LAT_LAST) begin
                            vrst_d    = 1'b1;
                            lat_cnt_d = '0;
                            state_d   = done_d ? ST_DRAIN : ST_RUN;
                        end
                    end else if (last_pix) begin
                        state_d   = ST_DRAIN;
                        lat_cnt_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (I_DE) err_set = 1'b1;
                lat_cnt_d = lat_cnt_q + CNT_W'(1);
                if (lat_cnt_q == LAT_LAST) begin
                    lat_cnt_d   = '0;
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                    state_d     = I_ENABLE ? ST_ARMED : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_d     = err_set | (err_q & ~I_ERR_CLR);
        pipe_en_d = (state_d == ST_FILL) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q     <= ST_IDLE;
            vs_dly_q    <= 1'b0;
            de_dly_q    <= 1'b0;
            lat_cnt_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            done_q      <= 1'b0;
            pipe_en_q   <= 1'b0;
            vrst_q      <= 1'b0;
            pix_col_q   <= '0;
            pix_row_q   <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            vs_dly_q    <= I_VSYNC;
            de_dly_q    <= I_DE;
            lat_cnt_q   <= lat_cnt_d;
            col_q       <= col_d;
            row_q       <= row_d;
            done_q      <= done_d;
            pipe_en_q   <= pipe_en_d;
            vrst_q      <= vrst_d;
            pix_col_q   <= pix_col_d;
            pix_row_q   <= pix_row_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign O_PIPE_EN   = pipe_en_q;
    assign O_VRST      = vrst_q;
    assign O_PIX_COL   = pix_col_q;
    assign O_PIX_ROW   = pix_row_q;
    assign O_STATE     = state_q;
    assign O_ERR       = err_q;
    assign O_FRAME_CNT = frame_cnt_q;

endmodule
